match_flow_ctrl: RTL and testbench

//  Match sequencer that sits directly upstream of the physics step engine and the seven-seg timer display.
//  - Converts the one-pulsed start/pause button into a run/pause/over state machine.
//  - Generates the per-frame step strobe and the seconds-remaining countdown.
//  - Watches both players' scores, ends the match on win or timeout, and latches the winner.

---
 rtl/match_flow_ctrl.sv | 120 ++++++++++++
 tb/tb_match_flow_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_flow_ctrl.sv
// Match sequencer: IDLE/RUN/PAUSE/OVER control, frame strobe, seconds countdown
// and winner latch for the step engine and the seven-seg timer.
module match_flow_ctrl #(
    parameter int unsigned FRAME_DIV  = 833333,
    parameter int unsigned SEC_DIV    = 100000000,
    parameter int unsigned MATCH_SECS = 180,
    parameter int unsigned WIN_SCORE  = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_pulse,
    input  logic [8:0] l_score,
    input  logic [8:0] r_score,
    output logic       step_en,
    output logic [7:0] secs_left,
    output logic [1:0] state,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int SW = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        OVER  = 2'b11
    } state_t;

    state_t        r_state, w_state_next;
    logic [FW-1:0] r_frame, w_frame_next;
    logic [SW-1:0] r_sec, w_sec_next;
    logic [7:0]    r_secs, w_secs_next;
    logic          r_step, w_step_next;
    logic          r_over;
    logic [1:0]    r_winner, w_winner_next;

    logic w_frame_wrap, w_sec_wrap, w_score_hit, w_timeout, w_end;

    assign w_frame_wrap = (r_frame == FW'(FRAME_DIV - 1));
    assign w_sec_wrap   = (r_sec == SW'(SEC_DIV - 1));
    assign w_score_hit  = (l_score >= 9'(WIN_SCORE)) || (r_score >= 9'(WIN_SCORE));
    assign w_timeout    = w_sec_wrap && (r_secs == 8'd1);
    assign w_end        = w_score_hit || w_timeout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_frame  <= '0;
            r_sec    <= '0;
            r_secs   <= 8'(MATCH_SECS);
            r_step   <= 1'b0;
            r_over   <= 1'b0;
            r_winner <= 2'b00;
        end else begin
            r_state  <= w_state_next;
            r_frame  <= w_frame_next;
            r_sec    <= w_sec_next;
            r_secs   <= w_secs_next;
            r_step   <= w_step_next;
            r_over   <= (w_state_next == OVER);
            r_winner <= w_winner_next;
        end
    end

    // The edge that leaves RUN still advances the counters, so a pause resumes
    // exactly where the last RUN cycle left the frame and second phase.
    always_comb begin
        w_state_next  = r_state;
        w_frame_next  = r_frame;
        w_sec_next    = r_sec;
        w_secs_next   = r_secs;
        w_step_next   = 1'b0;
        w_winner_next = r_winner;
        case (r_state)
            IDLE: begin
                w_frame_next  = '0;
                w_sec_next    = '0;
                w_secs_next   = 8'(MATCH_SECS);
                w_winner_next = 2'b00;
                if (start_pulse) w_state_next = RUN;
            end
            RUN: begin
                w_frame_next = w_frame_wrap ? '0 : r_frame + FW'(1);
                w_sec_next   = w_sec_wrap ? '0 : r_sec + SW'(1);
                if (w_sec_wrap && (r_secs != 8'd0)) w_secs_next = r_secs - 8'd1;
                if (w_end) begin
                    w_state_next  = OVER;
                    w_winner_next = (l_score > r_score) ? 2'b01 :
                                    (r_score > l_score) ? 2'b10 : 2'b11;
                end else if (start_pulse) begin
                    w_state_next = PAUSE;
                end else begin
                    w_step_next = w_frame_wrap;
                end
            end
            PAUSE: begin
                if (start_pulse) w_state_next = RUN;
            end
            OVER: begin
                if (start_pulse) begin
                    w_state_next  = IDLE;
                    w_frame_next  = '0;
                    w_sec_next    = '0;
                    w_secs_next   = 8'(MATCH_SECS);
                    w_winner_next = 2'b00;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign step_en   = r_step;
    assign secs_left = r_secs;
    assign state     = r_state;
    assign game_over = r_over;
    assign winner    = r_winner;

endmodule

// File: tb/tb_match_flow_ctrl.sv
// Self-checking bench for match_flow_ctrl with small dividers; expected output
// snapshots are queued as each cycle is driven and compared after the edge.
module tb_match_flow_ctrl;

    localparam int unsigned FRAME_DIV  = 4;
    localparam int unsigned SEC_DIV    = 10;
    localparam int unsigned MATCH_SECS = 3;
    localparam int unsigned WIN_SCORE  = 5;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_OVER  = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_pulse;
    logic [8:0] l_score;
    logic [8:0] r_score;
    logic       step_en;
    logic [7:0] secs_left;
    logic [1:0] state;
    logic       game_over;
    logic [1:0] winner;

    int errors = 0;
    int checks = 0;
    logic [13:0] expQ[$];
    logic [13:0] expv;

    match_flow_ctrl #(
        .FRAME_DIV (FRAME_DIV),
        .SEC_DIV   (SEC_DIV),
        .MATCH_SECS(MATCH_SECS),
        .WIN_SCORE (WIN_SCORE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_pulse(start_pulse),
        .l_score    (l_score),
        .r_score    (r_score),
        .step_en    (step_en),
        .secs_left  (secs_left),
        .state      (state),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] mk(input logic st_en, input int secs, input logic [1:0] st,
                                       input logic ov, input logic [1:0] w);
        return {st_en, 8'(secs), st, ov, w};
    endfunction

    function automatic logic [13:0] snap();
        return {step_en, secs_left, state, game_over, winner};
    endfunction

    function automatic string fmt(input logic [13:0] v);
        return $sformatf("step=%b secs=%0d state=%b over=%b winner=%b",
                         v[13], v[12:5], v[4:3], v[2], v[1:0]);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        start_pulse = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        l_score = '0;
        r_score = '0;
        for (int i = 0; i < 2; i++) begin
            start_pulse = (i == 1);
            expQ.push_back(mk(1'b0, 3, S_IDLE, 1'b0, 2'b00));
            @(posedge clk); #1;
            expv = expQ.pop_front(); checks++;
            if (snap() !== expv) begin
                errors++;
                $display("[TB] FAIL reset[%0d]: got %s, want %s", i, fmt(snap()), fmt(expv));
            end
        end
        rst_n = 1'b1;
        start_pulse = 1'b0;
        expQ.push_back(mk(1'b0, 3, S_IDLE, 1'b0, 2'b00));
        @(posedge clk); #1;
        expv = expQ.pop_front(); checks++;
        if (snap() !== expv) begin
            errors++;
            $display("[TB] FAIL idle_hold: got %s, want %s", fmt(snap()), fmt(expv));
        end
    endtask

    task automatic test_run_steps();
        l_score = 9'd4;
        r_score = 9'd4;
        for (int k = 0; k <= 14; k++) begin
            start_pulse = (k == 0);
            expQ.push_back(mk(k > 0 && k % 4 == 0, (k >= 10) ? 2 : 3, S_RUN, 1'b0, 2'b00));
            @(posedge clk); #1;
            expv = expQ.pop_front(); checks++;
            if (snap() !== expv) begin
                errors++;
                $display("[TB] FAIL run_steps k=%0d: got %s, want %s", k, fmt(snap()), fmt(expv));
            end
        end
        start_pulse = 1'b0;
    endtask

    task automatic test_pause();
        do_reset();
        l_score = '0;
        r_score = '0;
        for (int k = 0; k <= 5; k++) begin
            start_pulse = (k == 0);
            expQ.push_back(mk(k == 4, 3, S_RUN, 1'b0, 2'b00));
            @(posedge clk); #1;
            expv = expQ.pop_front(); checks++;
            if (snap() !== expv) begin
                errors++;
                $display("[TB] FAIL pause_run k=%0d: got %s, want %s", k, fmt(snap()), fmt(expv));
            end
        end
        // A winning score during PAUSE must be ignored.
        for (int p = 0; p <= 20; p++) begin
            start_pulse = (p == 0);
            l_score = (p == 0) ? 9'd0 : 9'd6;
            expQ.push_back(mk(1'b0, 3, S_PAUSE, 1'b0, 2'b00));
            @(posedge clk); #1;
            expv = expQ.pop_front(); checks++;
            if (snap() !== expv) begin
                errors++;
                $display("[TB] FAIL paused p=%0d: got %s, want %s", p, fmt(snap()), fmt(expv));
            end
        end
        l_score = '0;
        for (int r = 0; r <= 6; r++) begin
            start_pulse = (r == 0);
            expQ.push_back(mk(r == 2 || r == 6, (r >= 4) ? 2 : 3, S_RUN, 1'b0, 2'b00));
            @(posedge clk); #1;
            expv = expQ.pop_front(); checks++;
            if (snap() !== expv) begin
                errors++;
                $display("[TB] FAIL resume r=%0d: got %s, want %s", r, fmt(snap()), fmt(expv));
            end
        end
        start_pulse = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        l_score = 9'd2;
        r_score = 9'd2;
        for (int k = 0; k <= 34; k++) begin
            start_pulse = (k == 0);
            if (k < 30) expQ.push_back(mk(k > 0 && k % 4 == 0, 3 - k / 10, S_RUN, 1'b0, 2'b00));
            else        expQ.push_back(mk(1'b0, 0, S_OVER, 1'b1, 2'b11));
            @(posedge clk); #1;
            expv = expQ.pop_front(); checks++;
            if (snap() !== expv) begin
                errors++;
                $display("[TB] FAIL timeout k=%0d: got %s, want %s", k, fmt(snap()), fmt(expv));
            end
        end
        start_pulse = 1'b0;
    endtask

    task automatic test_score_win();
        do_reset();
        l_score = '0;
        r_score = '0;
        for (int k = 0; k <= 3; k++) begin
            start_pulse = (k == 0);
            expQ.push_back(mk(1'b0, 3, S_RUN, 1'b0, 2'b00));
            @(posedge clk); #1;
            expv = expQ.pop_front(); checks++;
            if (snap() !== expv) begin
                errors++;
                $display("[TB] FAIL win_run k=%0d: got %s, want %s", k, fmt(snap()), fmt(expv));
            end
        end
        // Score hit coincides with a frame wrap and a start press.
        l_score = 9'd3;
        r_score = 9'd5;
        for (int k = 0; k < 3; k++) begin
            start_pulse = (k == 0);
            expQ.push_back(mk(1'b0, 3, S_OVER, 1'b1, 2'b10));
            @(posedge clk); #1;
            expv = expQ.pop_front(); checks++;
            if (snap() !== expv) begin
                errors++;
                $display("[TB] FAIL win_right k=%0d: got %s, want %s", k, fmt(snap()), fmt(expv));
            end
        end
        start_pulse = 1'b0;
    endtask

    task automatic test_over_to_idle();
        for (int k = 0; k < 6; k++) begin
            start_pulse = (k == 0) || (k == 3) || (k == 5);
            if (k == 3) begin
                l_score = 9'd7;
                r_score = 9'd2;
            end
            case (k)
                3:       expQ.push_back(mk(1'b0, 3, S_RUN, 1'b0, 2'b00));
                4:       expQ.push_back(mk(1'b0, 3, S_OVER, 1'b1, 2'b01));
                default: expQ.push_back(mk(1'b0, 3, S_IDLE, 1'b0, 2'b00));
            endcase
            @(posedge clk); #1;
            expv = expQ.pop_front(); checks++;
            if (snap() !== expv) begin
                errors++;
                $display("[TB] FAIL over_idle k=%0d: got %s, want %s", k, fmt(snap()), fmt(expv));
            end
        end
        start_pulse = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        l_score = '0;
        r_score = '0;
        for (int k = 0; k <= 5; k++) begin
            start_pulse = (k == 0) || (k == 4);
            rst_n = (k != 4);
            if (k <= 3) expQ.push_back(mk(1'b0, 3, S_RUN, 1'b0, 2'b00));
            else        expQ.push_back(mk(1'b0, 3, S_IDLE, 1'b0, 2'b00));
            @(posedge clk); #1;
            expv = expQ.pop_front(); checks++;
            if (snap() !== expv) begin
                errors++;
                $display("[TB] FAIL reset_mid k=%0d: got %s, want %s", k, fmt(snap()), fmt(expv));
            end
        end
        rst_n = 1'b1;
        start_pulse = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run_steps();
        test_pause();
        test_timeout();
        test_score_win();
        test_over_to_idle();
        test_reset_mid_run();
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard: got %0d leftover entries, want 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
